// File: rtl/taxi_prbs_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | taxi_prbs_mon_pkg: lock FSM state encoding and popcount helper        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package taxi_prbs_mon_pkg;

  localparam int MAX_POP_W = 64;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic int unsigned popcount(input logic [MAX_POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_POP_W; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/taxi_lfsr_prbs_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | taxi_lfsr_prbs_check: self-synchronising feed-forward PRBS checker    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module taxi_lfsr_prbs_check #(
  parameter int               LFSR_W      = 31,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 31'h10000001,
  parameter logic [LFSR_W-1:0] LFSR_INIT  = '1,
  parameter logic             LFSR_GALOIS = 1'b0,
  parameter logic             REVERSE     = 1'b0,
  parameter logic             INVERT      = 1'b1,
  parameter int               DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out
);

  logic [LFSR_W-1:0] state_q, state_d;
  logic [DATA_W-1:0] err_q, err_d;
  logic [LFSR_W-1:0] st;
  logic              b;
  logic              e;
  int                idx;

  // The state is loaded from received bits, so any corruption flushes out after LFSR_W bits.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    st      = state_q;
    b       = 1'b0;
    e       = 1'b0;
    idx     = 0;
    if (data_in_valid) begin
      for (int i = 0; i < DATA_W; i++) begin
        idx = REVERSE ? i : (DATA_W - 1 - i);
        b   = data_in[idx] ^ INVERT;
        if (LFSR_GALOIS) begin
          e  = b ^ st[LFSR_W-1];
          st = {st[LFSR_W-2:0], 1'b0} ^ (b ? LFSR_POLY : '0);
        end else begin
          e  = b ^ (^(st & LFSR_POLY));
          st = {b, st[LFSR_W-1:1]};
        end
        err_d[idx] = e;
      end
      state_d = st;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_INIT;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign data_out = err_q;

endmodule
`default_nettype wire

// File: rtl/taxi_prbs_mon.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | taxi_prbs_mon: PRBS RX monitor with lock FSM and error statistics     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module taxi_prbs_mon
  import taxi_prbs_mon_pkg::*;
#(
  parameter int               LFSR_W      = 31,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 31'h10000001,
  parameter logic [LFSR_W-1:0] LFSR_INIT  = '1,
  parameter logic             LFSR_GALOIS = 1'b0,
  parameter logic             REVERSE     = 1'b0,
  parameter logic             INVERT      = 1'b1,
  parameter int               DATA_W      = 8,
  parameter int               CNT_W       = 32,
  parameter int               LOCK_CNT    = 64,
  parameter int               WINDOW      = 256,
  parameter int               UNLOCK_ERR  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              clear,
  output logic              locked,
  output logic              lock_loss,
  output logic              err_word,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int PC_W  = $clog2(DATA_W + 1);
  localparam int CL_W  = $clog2(LOCK_CNT + 1);
  localparam int WN_W  = $clog2(WINDOW + 1);
  localparam int SUM_W = CNT_W + 1;

  localparam logic [CL_W-1:0] C_LOCK_CNT   = CL_W'(LOCK_CNT);
  localparam logic [WN_W-1:0] C_WINDOW     = WN_W'(WINDOW);
  localparam logic [WN_W-1:0] C_UNLOCK_ERR = WN_W'(UNLOCK_ERR);

  logic [DATA_W-1:0] chk_err;
  logic              chk_valid_q, chk_valid_d;
  logic [PC_W-1:0]   pc;
  logic              word_bad;

  state_e            state_q, state_d;
  logic [CL_W-1:0]   clean_q, clean_d, clean_nxt;
  logic [WN_W-1:0]   win_q, win_d, win_nxt;
  logic [WN_W-1:0]   bad_q, bad_d, bad_nxt;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [SUM_W-1:0]  err_sum, word_sum;
  logic              locked_q, locked_d;
  logic              lock_loss_q, lock_loss_d;
  logic              err_word_q, err_word_d;

  taxi_lfsr_prbs_check #(
    .LFSR_W      (LFSR_W),
    .LFSR_POLY   (LFSR_POLY),
    .LFSR_INIT   (LFSR_INIT),
    .LFSR_GALOIS (LFSR_GALOIS),
    .REVERSE     (REVERSE),
    .INVERT      (INVERT),
    .DATA_W      (DATA_W)
  ) u_check (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_out      (chk_err)
  );

  assign chk_valid_d = data_in_valid;
  assign pc          = PC_W'(popcount(MAX_POP_W'(chk_err)));
  assign word_bad    = (pc != '0);

  always_comb begin
    state_d     = state_q;
    clean_d     = clean_q;
    win_d       = win_q;
    bad_d       = bad_q;
    lock_loss_d = 1'b0;
    err_word_d  = chk_valid_q && word_bad;
    clean_nxt   = word_bad ? '0 : clean_q + 1'b1;
    win_nxt     = win_q + 1'b1;
    bad_nxt     = bad_q + WN_W'(word_bad);
    // A clear restarts from zero but still keeps the increment of this cycle's word.
    err_sum     = clear ? '0 : {1'b0, err_cnt_q};
    word_sum    = clear ? '0 : {1'b0, word_cnt_q};
    if (chk_valid_q) begin
      case (state_q)
        ST_HUNT: begin
          if (clean_nxt == C_LOCK_CNT) begin
            state_d = ST_LOCKED;
            clean_d = '0;
            win_d   = '0;
            bad_d   = '0;
          end else begin
            clean_d = clean_nxt;
          end
        end
        ST_LOCKED: begin
          err_sum  = err_sum + SUM_W'(pc);
          word_sum = word_sum + SUM_W'(1);
          if (bad_nxt == C_UNLOCK_ERR) begin
            state_d     = ST_HUNT;
            lock_loss_d = 1'b1;
            clean_d     = '0;
            win_d       = '0;
            bad_d       = '0;
          end else if (win_nxt == C_WINDOW) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_nxt;
            bad_d = bad_nxt;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    err_cnt_d  = err_sum[CNT_W]  ? '1 : err_sum[CNT_W-1:0];
    word_cnt_d = word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
    locked_d   = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid_q <= 1'b0;
      state_q     <= ST_HUNT;
      clean_q     <= '0;
      win_q       <= '0;
      bad_q       <= '0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      locked_q    <= 1'b0;
      lock_loss_q <= 1'b0;
      err_word_q  <= 1'b0;
    end else begin
      chk_valid_q <= chk_valid_d;
      state_q     <= state_d;
      clean_q     <= clean_d;
      win_q       <= win_d;
      bad_q       <= bad_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      locked_q    <= locked_d;
      lock_loss_q <= lock_loss_d;
      err_word_q  <= err_word_d;
    end
  end

  assign locked    = locked_q;
  assign lock_loss = lock_loss_q;
  assign err_word  = err_word_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_taxi_prbs_mon.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_taxi_prbs_mon: random PRBS traffic against a reference model       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_taxi_prbs_mon;

  localparam int     DATA_W     = 8;
  localparam int     CNT_W      = 6;
  localparam int     LOCK_CNT   = 64;
  localparam int     WINDOW     = 256;
  localparam int     UNLOCK_ERR = 16;
  localparam longint MAXC       = (64'd1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              clear = 1'b0;
  logic              locked, lock_loss, err_word;
  logic [CNT_W-1:0]  err_cnt, word_cnt;

  always #5 clk = ~clk;

  taxi_prbs_mon #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .LOCK_CNT   (LOCK_CNT),
    .WINDOW     (WINDOW),
    .UNLOCK_ERR (UNLOCK_ERR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .clear         (clear),
    .locked        (locked),
    .lock_loss     (lock_loss),
    .err_word      (err_word),
    .err_cnt       (err_cnt),
    .word_cnt      (word_cnt)
  );

  typedef struct {
    logic             locked;
    logic             lock_loss;
    logic             err_word;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] word_cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: bit histories (index 0 = 31 bits ago, index 28 = 3 bits ago) and lock bookkeeping.
  bit     gen_h[$];
  bit     rx_h[$];
  bit     m_locked;
  int     m_clean, m_win, m_bad;
  longint m_err, m_word;
  bit     p_valid;
  int     p_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rx_h.delete();
    for (int i = 0; i < 31; i++) rx_h.push_back(1'b1);
    m_locked = 0; m_clean = 0; m_win = 0; m_bad = 0;
    m_err = 0; m_word = 0; p_valid = 0; p_pc = 0;
  endfunction

  function automatic logic [DATA_W-1:0] gen_word();
    logic [DATA_W-1:0] w;
    bit g;
    w = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      g = gen_h[28] ^ gen_h[0];
      gen_h.push_back(g);
      void'(gen_h.pop_front());
      w[i] = ~g;
    end
    return w;
  endfunction

  function automatic int check_word(input logic [DATA_W-1:0] d);
    int cnt;
    bit b;
    cnt = 0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b = ~d[i];
      if (b ^ rx_h[28] ^ rx_h[0]) cnt++;
      rx_h.push_back(b);
      void'(rx_h.pop_front());
    end
    return cnt;
  endfunction

  // One clock of stimulus; the pushed record is what the outputs must show after the next edge.
  task automatic step(input logic [DATA_W-1:0] d, input bit v, input bit clr, input bit r);
    exp_t   e;
    longint be, bw;
    @(negedge clk);
    data_in = d; data_in_valid = v; clear = clr; rst = r;
    e = '{locked: 1'b0, lock_loss: 1'b0, err_word: 1'b0, err_cnt: '0, word_cnt: '0};
    if (r) begin
      model_reset();
    end else begin
      e.err_word = p_valid && (p_pc != 0);
      be = clr ? 0 : m_err;
      bw = clr ? 0 : m_word;
      if (p_valid && m_locked) begin
        be += p_pc;
        bw += 1;
        m_win++;
        if (p_pc != 0) m_bad++;
        if (m_bad >= UNLOCK_ERR) begin
          m_locked = 0; e.lock_loss = 1'b1; m_clean = 0;
        end else if (m_win >= WINDOW) begin
          m_win = 0; m_bad = 0;
        end
      end else if (p_valid) begin
        m_clean = (p_pc == 0) ? m_clean + 1 : 0;
        if (m_clean >= LOCK_CNT) begin
          m_locked = 1; m_clean = 0; m_win = 0; m_bad = 0;
        end
      end
      m_err  = (be > MAXC) ? MAXC : be;
      m_word = (bw > MAXC) ? MAXC : bw;
      e.locked   = m_locked;
      e.err_cnt  = CNT_W'(m_err);
      e.word_cnt = CNT_W'(m_word);
      p_valid = v;
      if (v) p_pc = check_word(d);
    end
    sb.push_back(e);
  endtask

  task automatic send(input int n, input bit gaps, input bit rclr);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 7) == 0) step(8'($urandom), 1'b0, 1'b0, 1'b0);
      step(gen_word(), 1'b1, rclr && ($urandom_range(0, 31) == 0), 1'b0);
    end
  endtask

  task automatic send_flip();
    logic [DATA_W-1:0] w;
    w = gen_word();
    w[$urandom_range(0, DATA_W - 1)] ^= 1'b1;
    step(w, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_burst(input int n, input int clr_at);
    logic [DATA_W-1:0] m;
    for (int k = 0; k < n; k++) begin
      m = 8'($urandom_range(1, 255));
      step(gen_word() ^ m, 1'b1, (k == clr_at), 1'b0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("locked",    64'(locked),    64'(e.locked));
      chk("lock_loss", 64'(lock_loss), 64'(e.lock_loss));
      chk("err_word",  64'(err_word),  64'(e.err_word));
      chk("err_cnt",   64'(err_cnt),   64'(e.err_cnt));
      chk("word_cnt",  64'(word_cnt),  64'(e.word_cnt));
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < 31; i++) gen_h.push_back(bit'($urandom_range(0, 1)));
    gen_h[0] = 1'b1;

    repeat (3) step('0, 1'b0, 1'b0, 1'b1);
    send(120, 1'b1, 1'b0);
    chk("locked_after_clean_run", 64'(locked), 64'd1);

    send(30, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_flip();
      send(40, 1'b0, 1'b0);
    end

    send_burst(16, -1);
    send(3, 1'b0, 1'b0);
    chk("unlocked_after_burst", 64'(locked), 64'd0);
    send(100, 1'b1, 1'b0);
    chk("relocked_after_burst", 64'(locked), 64'd1);

    // Sparse single-bit errors: at most 15 errored words per window, so lock must hold.
    step(gen_word(), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) begin
      send_flip();
      send(59, 1'b0, 1'b0);
    end
    chk("locked_sparse_errors", 64'(locked), 64'd1);

    send_burst(30, 20);
    send(100, 1'b1, 1'b0);
    send_burst(12, 6);
    send(20, 1'b1, 1'b0);

    step(gen_word(), 1'b1, 1'b0, 1'b1);
    step(8'($urandom), 1'b0, 1'b0, 1'b1);
    send(120, 1'b1, 1'b1);
    chk("relocked_after_rst", 64'(locked), 64'd1);

    repeat (4) step('0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected records left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
